spad_fsm: RTL and testbench
===========================

// Module: spad_fsm
// PURPOSE
// - Frame sequencer between FPGA fabric and the SPAD imager IC: clears the IC memory, opens
//   a laser-synchronous photon window, then scans every pixel address and pushes one 16-bit
//   word per pixel to the readout FIFO.
// - Sits between the PLL (spad_on_clk, pll_locked), the IC pads and the host FIFO write port.
// PARAMETERS
// - CLEAR_CYCLES  4  clk cycles MEM_CLEAR is held high per frame
// - READ_CYCLES   2  clk cycles READ_EN is held high before the scan starts
// - SYNC_STAGES   2  flops in the spad_on_clk / pll_locked synchronisers (>=2)
// PORTS
// - clk            in   1   80 MHz system clock; the only clock domain
// - rst            in   1   asynchronous, active-low reset
// - en             in   1   frame enable
// - pll_locked     in   1   PLL lock; async, synchronised internally
// - spad_on_clk    in   1   20 MHz laser-synchronous clock, sampled (not used as a clock)
// - window_cycles  in   2   photon windows per frame; 0 means 4
// - DIN            in   5   pixel data from IC
// - PROBE_SEL      out  1   address MSB (probe bank)
// - ADDR           out  6   row/column address
// - PIX_SEL        out  3   pixel select within address
// - MEM_CLEAR      out  1   global IC memory clear
// - READ_EN        out  1   IC data-update request
// - SPAD_ON_CLK_EN out  1   photon-gathering gate
// - dout           out  16  {PROBE_SEL,ADDR,PIX_SEL,1'b0,DIN}
// - req_fifowr     out  1   one-cycle FIFO write strobe, dout valid while high
// BEHAVIOUR
// - Reset (rst=0): state IDLE, all outputs 0, counters 0; effective immediately.
// - Every output is registered. Pixel address = {PROBE_SEL,ADDR,PIX_SEL}, 10 bits, 0..1023.
// - IDLE: en=1 -> CLEAR.
// - CLEAR: MEM_CLEAR=1 for CLEAR_CYCLES cycles -> WAIT_LOCK.
// - WAIT_LOCK: synchronised pll_locked=1 -> EXPOSE; window counter cleared.
// - EXPOSE: SPAD_ON_CLK_EN=1. Rising edges of synchronised spad_on_clk are counted.
//   At N edges (N=window_cycles, 0 means 4), SPAD_ON_CLK_EN drops next cycle -> READ.
//   window_cycles is sampled on entry to EXPOSE; changes apply from the next frame.
//   pll_locked drops -> SPAD_ON_CLK_EN=0 next cycle, back to WAIT_LOCK, count restarts.
//   en drops -> SPAD_ON_CLK_EN=0, go IDLE (frame aborted, no FIFO writes).
// - READ: READ_EN=1 for READ_CYCLES cycles, address reset to 0 -> SCAN.
// - SCAN: two clk cycles per pixel. Phase 0 drives the address. Phase 1 samples DIN.
//   On the following edge dout={addr,1'b0,DIN} and req_fifowr=1 for exactly one cycle.
//   The address then increments. After address 1023 wraps to 0: en=1 -> CLEAR, else IDLE.
//   en dropping mid-scan does not abort; the frame completes all 1024 writes.
// - req_fifowr never high in two consecutive cycles; 1024 strobes per full frame.
// - Reset mid-frame: immediate return to IDLE with all outputs low.
// CONFIGURATION
// - SPAD_FSM_SKIP_ZERO_EN defined: in SCAN, req_fifowr is suppressed when sampled DIN==0.
//   The address still advances and scan timing is unchanged.
// - Undefined (default): every pixel is written, including DIN==0.
// TESTING
// - rst=0 then release, en=0 -> all outputs 0, stays IDLE indefinitely.
// - en=1, pll_locked=1, window_cycles=2 -> MEM_CLEAR 4 cycles.
//   SPAD_ON_CLK_EN high across exactly 2 spad_on_clk rising edges, then READ_EN 2 cycles.
// - DIN=5'b10011 constant -> 1024 strobes 2 cycles apart; first dout=16'h0013, last 16'hFFD3.
// - pll_locked dropped mid-EXPOSE -> SPAD_ON_CLK_EN low next cycle.
//   Re-lock restarts full window count.
// - en=0 during SCAN at address 100 -> scan finishes to 1023, then IDLE, no new MEM_CLEAR.
// - SPAD_FSM_SKIP_ZERO_EN defined, DIN=0 -> zero strobes, frame length unchanged.

Source files
------------

// File: rtl/spad_fsm.sv
//------------------------------------------------------------------------------
// Module      : spad_fsm
// Description : Frame sequencer for the SPAD imager IC. Clears the IC memory,
//               gates a laser-synchronous photon window, then scans all 1024
//               pixel addresses and emits one 16-bit word per pixel to the
//               readout FIFO.
//               Optional build macro: SPAD_FSM_SKIP_ZERO_EN -- suppresses the
//               FIFO write for pixels whose sampled DIN is zero.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spad_fsm #(
  parameter int CLEAR_CYCLES = 4,
  parameter int READ_CYCLES  = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        pll_locked,
  input  logic        spad_on_clk,
  input  logic [1:0]  window_cycles,
  input  logic [4:0]  DIN,
  output logic        PROBE_SEL,
  output logic [5:0]  ADDR,
  output logic [2:0]  PIX_SEL,
  output logic        MEM_CLEAR,
  output logic        READ_EN,
  output logic        SPAD_ON_CLK_EN,
  output logic [15:0] dout,
  output logic        req_fifowr
);

  // Shared down-counter for the CLEAR and READ hold phases.
  localparam int c_CNT_MAX = (CLEAR_CYCLES > READ_CYCLES) ? CLEAR_CYCLES : READ_CYCLES;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_CLEAR_LAST = c_CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_READ_LAST  = c_CNT_W'(READ_CYCLES - 1);
  localparam logic [9:0]         c_ADDR_LAST  = 10'h3FF;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_EXPOSE    = 3'd3,
    S_READ      = 3'd4,
    S_SCAN      = 3'd5
  } state_t;

  state_t                 r_state;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [2:0]             r_win_cnt;
  logic [2:0]             r_win_tgt;
  logic [9:0]             r_addr;
  logic                   r_phase;
  logic                   r_mem_clear;
  logic                   r_read_en;
  logic                   r_spad_en;
  logic [15:0]            r_dout;
  logic                   r_req;

  logic [SYNC_STAGES-1:0] r_spad_sync;
  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic                   r_spad_prev;

  logic                   w_locked;
  logic                   w_spad_rise;

  assign w_locked    = r_lock_sync[SYNC_STAGES-1];
  assign w_spad_rise = r_spad_sync[SYNC_STAGES-1] & ~r_spad_prev;

  // Bring the asynchronous lock flag and laser clock into the clk domain and
  // keep one extra stage of the laser clock for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_spad_sync <= '0;
      r_lock_sync <= '0;
      r_spad_prev <= 1'b0;
    end else begin
      r_spad_sync <= {r_spad_sync[SYNC_STAGES-2:0], spad_on_clk};
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked};
      r_spad_prev <= r_spad_sync[SYNC_STAGES-1];
    end
  end

  // Frame sequencer: every output is produced directly from a register here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_win_cnt   <= 3'd0;
      r_win_tgt   <= 3'd0;
      r_addr      <= 10'd0;
      r_phase     <= 1'b0;
      r_mem_clear <= 1'b0;
      r_read_en   <= 1'b0;
      r_spad_en   <= 1'b0;
      r_dout      <= 16'd0;
      r_req       <= 1'b0;
    end else begin
      // The FIFO strobe is a single-cycle pulse unless re-armed below.
      r_req <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state     <= S_CLEAR;
            r_cnt       <= '0;
            r_mem_clear <= 1'b1;
          end
        end

        S_CLEAR: begin
          if (r_cnt == c_CLEAR_LAST) begin
            r_mem_clear <= 1'b0;
            r_state     <= S_WAIT_LOCK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          // Leaving here on en low avoids sitting forever on a PLL that never locks.
          if (!en) begin
            r_state <= S_IDLE;
          end else if (w_locked) begin
            r_state   <= S_EXPOSE;
            r_spad_en <= 1'b1;
            r_win_cnt <= 3'd0;
            // The window length is frozen for the whole exposure; 0 encodes 4.
            r_win_tgt <= (window_cycles == 2'd0) ? 3'd4 : {1'b0, window_cycles};
          end
        end

        S_EXPOSE: begin
          if (!en) begin
            r_spad_en <= 1'b0;
            r_state   <= S_IDLE;
          end else if (!w_locked) begin
            r_spad_en <= 1'b0;
            r_state   <= S_WAIT_LOCK;
          end else if (w_spad_rise) begin
            if (r_win_cnt + 3'd1 == r_win_tgt) begin
              r_spad_en <= 1'b0;
              r_read_en <= 1'b1;
              r_cnt     <= '0;
              r_state   <= S_READ;
            end else begin
              r_win_cnt <= r_win_cnt + 3'd1;
            end
          end
        end

        S_READ: begin
          if (r_cnt == c_READ_LAST) begin
            r_read_en <= 1'b0;
            r_addr    <= 10'd0;
            r_phase   <= 1'b0;
            r_state   <= S_SCAN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_SCAN: begin
          if (!r_phase) begin
            // Address has been on the pads for one cycle; let the IC settle.
            r_phase <= 1'b1;
          end else begin
            // DIN is captured together with the address it belongs to.
            r_phase <= 1'b0;
            r_dout  <= {r_addr, 1'b0, DIN};
`ifdef SPAD_FSM_SKIP_ZERO_EN
            r_req   <= (DIN != 5'd0);
`else
            r_req   <= 1'b1;
`endif
            r_addr  <= r_addr + 10'd1;
            if (r_addr == c_ADDR_LAST) begin
              // en is only consulted at frame end; a started scan always completes.
              if (en) begin
                r_state     <= S_CLEAR;
                r_cnt       <= '0;
                r_mem_clear <= 1'b1;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign PROBE_SEL      = r_addr[9];
  assign ADDR           = r_addr[8:3];
  assign PIX_SEL        = r_addr[2:0];
  assign MEM_CLEAR      = r_mem_clear;
  assign READ_EN        = r_read_en;
  assign SPAD_ON_CLK_EN = r_spad_en;
  assign dout           = r_dout;
  assign req_fifowr     = r_req;

endmodule

`default_nettype wire

// File: tb/tb_spad_fsm.sv
//------------------------------------------------------------------------------
// Module      : tb_spad_fsm
// Description : Directed self-checking bench for spad_fsm. Drives the laser
//               clock as explicit pulses so window edges land on known cycles.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spad_fsm;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        pll_locked;
  logic        spad_on_clk;
  logic [1:0]  window_cycles;
  logic [4:0]  din;
  logic        probe_sel;
  logic [5:0]  addr;
  logic [2:0]  pix_sel;
  logic        mem_clear;
  logic        read_en;
  logic        spad_en;
  logic [15:0] dout;
  logic        req;

  spad_fsm dut (
    .clk            (clk),
    .rst            (rst_n),
    .en             (en),
    .pll_locked     (pll_locked),
    .spad_on_clk    (spad_on_clk),
    .window_cycles  (window_cycles),
    .DIN            (din),
    .PROBE_SEL      (probe_sel),
    .ADDR           (addr),
    .PIX_SEL        (pix_sel),
    .MEM_CLEAR      (mem_clear),
    .READ_EN        (read_en),
    .SPAD_ON_CLK_EN (spad_en),
    .dout           (dout),
    .req_fifowr     (req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Activity monitor, sampled on the falling edge.
  int          cyc = 0;
  int          n_mc = 0;
  int          n_re = 0;
  int          n_wr = 0;
  int          n_b2b = 0;
  logic        prev_req = 1'b0;
  logic [15:0] wr_log [4096];
  int          wr_cyc [4096];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_clear) n_mc <= n_mc + 1;
    if (read_en)   n_re <= n_re + 1;
    if (req) begin
      if (n_wr < 4096) begin
        wr_log[n_wr] <= dout;
        wr_cyc[n_wr] <= cyc;
      end
      n_wr <= n_wr + 1;
      if (prev_req) n_b2b <= n_b2b + 1;
    end
    prev_req <= req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int probe(input int which);
    case (which)
      0:       return int'(spad_en);
      1:       return int'(read_en);
      2:       return int'(mem_clear);
      3:       return int'({probe_sel, addr, pix_sel});
      default: return n_wr;
    endcase
  endfunction

  task automatic wait_cond(input int which, input int val, input int limit, input string tag);
    int k = 0;
    while (probe(which) != val && k < limit) begin
      tick();
      k++;
    end
    chk(tag, probe(which), val);
  endtask

  // One laser-clock period: two cycles high, two low.
  task automatic spad_pulse();
    spad_on_clk = 1'b1;
    tick();
    tick();
    spad_on_clk = 1'b0;
    tick();
    tick();
  endtask

  function automatic logic [29:0] all_outs();
    return {probe_sel, addr, pix_sel, mem_clear, read_en, spad_en, req, dout};
  endfunction

  initial begin
    int          mark_mc;
    int          mark_re;
    int          mark_wr;
    int          bad;
    logic [9:0]  a;
    logic [15:0] e;

    rst_n         = 1'b0;
    en            = 1'b0;
    pll_locked    = 1'b0;
    spad_on_clk   = 1'b0;
    window_cycles = 2'd2;
    din           = 5'd0;
    tick();
    tick();
    chk("reset_outs", 32'(all_outs()), 32'd0);
    rst_n = 1'b1;
    repeat (20) tick();
    chk("idle_outs", 32'(all_outs()), 32'd0);
    chk("idle_no_clear", n_mc, 0);

    // Frame 1: window of 2 edges, constant pixel data.
    pll_locked = 1'b1;
    din        = 5'b10011;
    repeat (4) tick();
    mark_mc = n_mc;
    en = 1'b1;
    wait_cond(0, 1, 50, "expose1_entry");
    chk("clear_len", n_mc - mark_mc, 4);
    chk("clear_done", mem_clear, 1'b0);
    repeat (6) tick();
    chk("hold_no_edge", spad_en, 1'b1);
    spad_pulse();
    chk("after_edge1", spad_en, 1'b1);
    mark_re = n_re;
    spad_on_clk = 1'b1;
    tick();
    tick();
    chk("on_at_edge2", spad_en, 1'b1);
    tick();
    chk("off_after_edge2", spad_en, 1'b0);
    chk("read_start", read_en, 1'b1);
    spad_on_clk = 1'b0;
    wait_cond(1, 0, 10, "read1_end");
    chk("read_len", n_re - mark_re, 2);
    wait_cond(4, 1024, 2200, "frame1_writes");
    chk("restart_clear", mem_clear, 1'b1);
    chk("first_dout", wr_log[0], 16'h0013);
    chk("last_dout", wr_log[1023], 16'hFFD3);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      a = i[9:0];
      e = {a, 1'b0, 5'b10011};
      if (wr_log[i] !== e) bad++;
    end
    chk("dout_seq", bad, 0);
    chk("no_back_to_back", n_b2b, 0);
    chk("strobe_span", wr_cyc[1023] - wr_cyc[0], 2046);

    // Frame 2 (auto restart): lock loss mid-exposure, then en dropped mid-scan.
    wait_cond(0, 1, 50, "expose2_entry");
    spad_pulse();
    chk("f2_one_edge", spad_en, 1'b1);
    pll_locked = 1'b0;
    tick();
    tick();
    chk("lock_drop_hold", spad_en, 1'b1);
    tick();
    chk("lock_drop_off", spad_en, 1'b0);
    repeat (3) tick();
    pll_locked = 1'b1;
    wait_cond(0, 1, 50, "relock");
    spad_pulse();
    chk("relock_restart", spad_en, 1'b1);
    spad_on_clk = 1'b1;
    tick();
    tick();
    tick();
    chk("relock_off", spad_en, 1'b0);
    spad_on_clk = 1'b0;
    wait_cond(3, 100, 2200, "scan_addr100");
    en = 1'b0;
    wait_cond(4, 2048, 2200, "frame2_writes");
    chk("f2_end_no_clear", mem_clear, 1'b0);
    mark_mc = n_mc;
    repeat (20) tick();
    chk("f2_stays_idle", n_mc - mark_mc, 0);
    chk("f2_addr_zero", probe(3), 0);

    // Frame 3: en dropped during exposure aborts the frame.
    en = 1'b1;
    wait_cond(0, 1, 50, "expose3_entry");
    mark_re = n_re;
    mark_wr = n_wr;
    en = 1'b0;
    tick();
    chk("abort_off", spad_en, 1'b0);
    repeat (30) tick();
    chk("abort_no_read", n_re - mark_re, 0);
    chk("abort_no_writes", n_wr - mark_wr, 0);

    // Frame 4: all-zero pixel data, fixed scan length.
    din = 5'd0;
    en  = 1'b1;
    wait_cond(0, 1, 50, "expose4_entry");
    spad_pulse();
    spad_on_clk = 1'b1;
    tick();
    tick();
    tick();
    chk("f4_read_start", read_en, 1'b1);
    spad_on_clk = 1'b0;
    en = 1'b0;
    wait_cond(1, 0, 10, "read4_end");
    mark_wr = n_wr;
    repeat (2047) tick();
    chk("scan_len_last", probe(3), 1023);
    tick();
    chk("scan_len_wrap", probe(3), 0);
    chk("f4_no_clear", mem_clear, 1'b0);
`ifdef SPAD_FSM_SKIP_ZERO_EN
    chk("zero_din_writes", n_wr - mark_wr, 0);
`else
    chk("zero_din_writes", n_wr - mark_wr, 1024);
    chk("zero_din_last", wr_log[mark_wr + 1023], 16'hFFC0);
`endif

    // Reset asserted mid-frame takes effect without a clock edge.
    en = 1'b1;
    wait_cond(2, 1, 20, "clear5");
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(all_outs()), 32'd0);
    tick();
    rst_n = 1'b1;
    en    = 1'b0;
    repeat (5) tick();
    chk("post_reset_idle", 32'(all_outs()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
